// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle wide adder reusing one 4-bit cbadder slice, LS nibble first

module cbadder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout,
  output logic [3:0] sumog,
  output logic       coutog,
  output logic [3:0] sumpm,
  output logic       coutpm
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Carry-bypass slice: ripple inside, skip the ripple when all bits propagate;
  // also exposes a plain reference add and the propagate mask.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum              = p ^ c[3:0];
    cout             = (&p) ? cin : c[4];
    {coutog, sumog}  = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    sumpm            = p;
    coutpm           = &p;
  end

endmodule

module nibble_serial_adder #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic          carry_q;
  logic [IW-1:0] idx;
  logic [W-1:0]  sum_q;
  logic          cout_q;

  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    nib_sum;
  logic          nib_cout;

  assign nib_a = a_q[4*idx +: 4];
  assign nib_b = b_q[4*idx +: 4];

  cbadder u_slice (
    .a      (nib_a),
    .b      (nib_b),
    .cin    (carry_q),
    .sum    (nib_sum),
    .cout   (nib_cout),
    .sumog  (),
    .coutog (),
    .sumpm  (),
    .coutpm ()
  );

  // Control FSM: capture operands, walk the nibbles through the slice, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
            sum_q   <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum_q[4*idx +: 4] <= nib_sum;
          carry_q           <= nib_cout;
          if (idx == LAST) begin
            cout_q <= nib_cout;
            state  <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder

module tb_nibble_serial_adder;

  logic        clk;
  logic        rst;

  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        busy;

  logic        in_valid2;
  logic        in_ready2;
  logic [7:0]  a2;
  logic [7:0]  b2;
  logic        cin2;
  logic        out_valid2;
  logic        out_ready2;
  logic [7:0]  sum2;
  logic        cout2;
  logic        busy2;

  int total;
  int bad;

  nibble_serial_adder #(.NIBBLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  nibble_serial_adder #(.NIBBLES(2)) dut2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .a         (a2),
    .b         (b2),
    .cin       (cin2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .sum       (sum2),
    .cout      (cout2),
    .busy      (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full operation on the 16-bit instance with out_ready held high.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                        output logic [15:0] s, output logic c, output int lat, output int irhi);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    a = ~ta; b = ~tb_; cin = ~tc;
    lat = 1; irhi = 0;
    while (!out_valid && lat < 30) begin
      if (in_ready) irhi++;
      step();
      lat++;
    end
    s = sum; c = cout;
    step();
  endtask

  initial begin
    logic [15:0] s;
    logic        c;
    int          lat;
    int          irhi;
    int          n;
    int          seen;
    int          ops;
    int          hs;
    int          ta;
    int          tb2;
    int          e;
    logic        got;

    total = 0; bad = 0;
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; out_ready = 1'b0;
    in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b0;
    step();
    step();
    rst = 1'b0;

    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);

    run_op(16'h1234, 16'h4321, 1'b0, s, c, lat, irhi);
    chk("op1_latency", lat, 5);
    chk("op1_in_ready_low", irhi, 0);
    chk("op1_sum", s, 16'h5555);
    chk("op1_cout", c, 0);
    chk("op1_in_ready_after", in_ready, 1);
    chk("op1_out_valid_after", out_valid, 0);

    run_op(16'hFFFF, 16'h0001, 1'b0, s, c, lat, irhi);
    chk("ripple_sum", s, 16'h0000);
    chk("ripple_cout", c, 1);

    run_op(16'h0FFF, 16'h0001, 1'b0, s, c, lat, irhi);
    chk("ripple3_sum", s, 16'h1000);
    chk("ripple3_cout", c, 0);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, s, c, lat, irhi);
    chk("ones_cin_sum", s, 16'hFFFF);
    chk("ones_cin_cout", c, 1);

    run_op(16'h0000, 16'h0000, 1'b1, s, c, lat, irhi);
    chk("zero_cin_sum", s, 16'h0001);
    chk("zero_cin_cout", c, 0);

    // backpressure in DONE
    a = 16'h1111; b = 16'h2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("bp_reached_done", out_valid, 1);
    a = 16'h0102; b = 16'h0304; cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("bp_out_valid_hold", out_valid, 1);
      chk("bp_sum_hold", sum, 16'h3333);
      chk("bp_cout_hold", cout, 0);
      chk("bp_in_ready_low", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 30) begin
      step();
      n++;
    end
    chk("bp_next_sum", sum, 16'h0407);
    chk("bp_next_cout", cout, 0);
    step();

    // reset in the middle of RUN, at idx == 2
    a = 16'h00FF; b = 16'h0001; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("mid_rst_no_stale", seen, 0);
    run_op(16'h0003, 16'h0004, 1'b0, s, c, lat, irhi);
    chk("post_rst_sum", s, 16'h0007);
    chk("post_rst_cout", c, 0);

    // reset and in_valid together: nothing accepted
    rst = 1'b1; in_valid = 1'b1; a = 16'h5555; b = 16'h5555;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_vs_valid_busy", busy, 0);
    chk("rst_vs_valid_in_ready", in_ready, 1);

    // 8-bit instance sweep with random output stalls
    ops = 0; hs = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 18; j++) begin
        for (int k = 0; k < 2; k++) begin
          ta = i * 17;
          tb2 = (j * 15 > 255) ? 255 : j * 15;
          e = ta + tb2 + k;
          a2 = 8'(ta); b2 = 8'(tb2); cin2 = k[0]; in_valid2 = 1'b1;
          step();
          in_valid2 = 1'b0;
          ops++;
          got = 1'b0;
          n = 0;
          while (!got && n < 40) begin
            out_ready2 = 1'($urandom_range(0, 1));
            if (out_valid2 && out_ready2) begin
              got = 1'b1;
              hs++;
              chk("sweep_sum", sum2, 32'(e & 255));
              chk("sweep_cout", cout2, 32'(e >> 8));
            end
            step();
            n++;
          end
          out_ready2 = 1'b0;
          chk("sweep_done", got, 1);
          chk("sweep_single_valid", out_valid2, 0);
        end
      end
    end
    chk("sweep_handshakes", hs, ops);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
